// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE -> FETCH -> EXEC loop with jump/branch/sequential next-PC.
// Optional macro FETCH_HALT_EN: op 6'b111111 parks the unit in HALT until reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [4:0]  shamt,
  output logic        instr_valid,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] instr_q;
  logic        req_q;
  logic        iv_q;
  logic        halted_q;
  logic        halt_op;

`ifdef FETCH_HALT_EN
  assign halt_op = (instr_q[31:26] == 6'b111111);
`else
  assign halt_op = 1'b0;
`endif

  assign pcplus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pcplus4;
    if (jump) begin
      pc_d = {pcplus4[31:28], instr_q[25:0], 2'b00};
    end else if (pcsrc) begin
      pc_d = pcplus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    end
  end

  // Outputs are registered alongside the state so they change only with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pc_q     <= {RESET_PC[31:2], 2'b00};
      instr_q  <= '0;
      req_q    <= 1'b0;
      iv_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: begin
          if (imem_valid) begin
            instr_q <= imem_rdata;
            state_q <= EXEC;
            req_q   <= 1'b0;
            iv_q    <= 1'b1;
          end
        end
        EXEC: begin
          if (!stall) begin
            iv_q <= 1'b0;
            if (halt_op) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else begin
              pc_q    <= pc_d;
              state_q <= FETCH;
              req_q   <= 1'b1;
            end
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign shamt       = instr_q[10:6];
  assign instr_valid = iv_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver pushes expected fetch records, monitor pops on instr_valid.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        pcsrc, jump, stall;
  logic [31:0] pc, pcplus4, instr;
  logic [5:0]  op, funct;
  logic [4:0]  shamt;
  logic        instr_valid, halted;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic        w_pcsrc, w_jump, w_stall;
  logic [31:0] w_pc, w_pcplus4, w_instr;
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_shamt;
  logic        w_iv, w_halted;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .pcsrc(pcsrc), .jump(jump),
    .stall(stall), .pc(pc), .pcplus4(pcplus4), .instr(instr), .op(op), .funct(funct),
    .shamt(shamt), .instr_valid(instr_valid), .halted(halted)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset_n(reset_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .imem_valid(w_valid), .pcsrc(w_pcsrc), .jump(w_jump),
    .stall(w_stall), .pc(w_pc), .pcplus4(w_pcplus4), .instr(w_instr), .op(w_op),
    .funct(w_funct), .shamt(w_shamt), .instr_valid(w_iv), .halted(w_halted)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] model_pc;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                           input bit br, input bit jmp);
    logic [31:0]        seq;
    logic signed [15:0] imm;
    int                 off;
    seq = p + 32'd4;
    imm = ins[15:0];
    off = imm;
    if (jmp) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (br) return seq + 32'(off * 4);
    return seq;
  endfunction

  // Monitor: pops one record each time a new instruction appears in EXEC.
  initial begin
    exp_t cur;
    bit   prev_iv = 1'b0;
    bit   have = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en && reset_n) begin
        if (instr_valid && !prev_iv) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_exec: got instr %h expected no instruction", instr);
          end else begin
            cur = sb_q.pop_front();
            have = 1'b1;
            chk("exec_pc", pc, cur.pc);
            chk("exec_instr", instr, cur.instr);
            chk("exec_op", {26'b0, op}, {26'b0, cur.instr[31:26]});
            chk("exec_funct", {26'b0, funct}, {26'b0, cur.instr[5:0]});
            chk("exec_shamt", {27'b0, shamt}, {27'b0, cur.instr[10:6]});
            chk("exec_pcplus4", pcplus4, cur.pc + 32'd4);
            chk("exec_req", 32'(imem_req), 32'd0);
            chk("exec_halted", 32'(halted), 32'd0);
          end
        end else if (instr_valid && have) begin
          chk("stall_pc", pc, cur.pc);
          chk("stall_instr", instr, cur.instr);
          chk("stall_req", 32'(imem_req), 32'd0);
        end
        if (imem_req && sb_q.size() > 0) begin
          chk("fetch_addr", imem_addr, sb_q[0].pc);
          chk("fetch_iv", 32'(instr_valid), 32'd0);
        end
      end
      prev_iv = instr_valid;
    end
  end

  task automatic wait_req();
    bit ok = 1'b0;
    for (int unsigned i = 0; i < 50; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      imem_valid = 1'($urandom);
      imem_rdata = $urandom;
      @(negedge clk);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_req: imem_req=%b required 1 within 50 cycles", imem_req);
    end
  endtask

  task automatic do_txn(input logic [31:0] ins, input bit br, input bit jmp,
                        input int unsigned stalls, input int unsigned lat);
    sb_q.push_back('{model_pc, ins});
    wait_req();
    for (int unsigned i = 0; i < lat; i++) begin
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      pcsrc = 1'($urandom);
      jump = 1'($urandom);
      stall = 1'($urandom);
      @(negedge clk);
    end
    imem_valid = 1'b1;
    imem_rdata = ins;
    @(negedge clk);
    for (int unsigned i = 0; i < stalls; i++) begin
      imem_valid = 1'($urandom);
      imem_rdata = $urandom;
      stall = 1'b1;
      pcsrc = 1'($urandom);
      jump = 1'($urandom);
      @(negedge clk);
    end
    imem_valid = 1'($urandom);
    imem_rdata = $urandom;
    stall = 1'b0;
    pcsrc = br;
    jump = jmp;
    model_pc = ref_next(model_pc, ins, br, jmp);
    @(negedge clk);
    imem_valid = 1'b0;
    pcsrc = 1'($urandom);
    jump = 1'($urandom);
    stall = 1'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time exceeded 500000");
    $fatal(1);
  end

  initial begin
    logic [31:0] ins;
    reset_n = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    pcsrc = 1'b0;
    jump = 1'b0;
    stall = 1'b0;
    w_valid = 1'b0;
    w_rdata = '0;
    w_pcsrc = 1'b0;
    w_jump = 1'b0;
    w_stall = 1'b0;
    model_pc = 32'h0;

    @(negedge clk);
    imem_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_iv", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    imem_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    chk("idle_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("idle_exit_req", 32'(imem_req), 32'd1);
    mon_en = 1'b1;

    do_txn(32'h0123_4567, 1'b0, 1'b0, 0, 0);
    chk("first_seq_pc", pc, 32'h4);
    do_txn(32'h0800_0040, 1'b0, 1'b1, 0, 1);
    chk("jump_pc", pc, 32'h100);
    do_txn(32'h1000_FFFF, 1'b1, 1'b0, 0, 2);
    chk("branch_back_pc", pc, 32'h100);
    do_txn(32'h0800_0400, 1'b0, 1'b1, 1, 0);
    chk("jump_far_pc", pc, 32'h1000);
    do_txn(32'h0800_0040, 1'b1, 1'b1, 0, 0);
    chk("jump_prio_pc", pc, 32'h100);
    do_txn(32'h0000_0020, 1'b0, 1'b0, 3, 1);
    chk("stall_adv_pc", pc, 32'h104);
`ifndef FETCH_HALT_EN
    do_txn(32'hFC00_0000, 1'b0, 1'b0, 0, 0);
    chk("op3f_seq_pc", pc, 32'h108);
    chk("op3f_halted", 32'(halted), 32'd0);
`endif

    for (int unsigned n = 0; n < 200; n++) begin
      ins = $urandom;
`ifdef FETCH_HALT_EN
      if (ins[31:26] == 6'b111111) ins[26] = 1'b0;
`endif
      do_txn(ins, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
             $urandom_range(0, 3), $urandom_range(0, 3));
    end
    chk("final_pc", pc, model_pc);
    mon_en = 1'b0;

    // Reset during FETCH with imem_valid arriving at the same moment.
    wait_req();
    imem_valid = 1'b0;
    #2;
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    reset_n = 1'b0;
    #1;
    chk("rf_req", 32'(imem_req), 32'd0);
    chk("rf_pc", pc, 32'h0);
    chk("rf_instr", instr, 32'h0);
    chk("rf_iv", 32'(instr_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("rf_no_latch", instr, 32'h0);
    chk("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    imem_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("wrap_addr", w_addr, 32'hFFFF_FFFC);
    chk("wrap_pcplus4", w_pcplus4, 32'h0);
    w_valid = 1'b1;
    w_rdata = 32'h0000_0020;
    @(negedge clk);
    w_valid = 1'b0;
    chk("wrap_iv", 32'(w_iv), 32'd1);
    @(negedge clk);
    chk("wrap_pc", w_pc, 32'h0);
    chk("wrap_req", 32'(w_req), 32'd1);

    // Reset during EXEC while stalled.
    stall = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("re_iv", 32'(instr_valid), 32'd1);
    chk("re_instr", instr, 32'h1234_5678);
    #2;
    reset_n = 1'b0;
    #1;
    chk("re_iv_clr", 32'(instr_valid), 32'd0);
    chk("re_instr_clr", instr, 32'h0);
    chk("re_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    imem_valid = 1'b0;
    stall = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

`ifdef FETCH_HALT_EN
    model_pc = 32'h0;
    sb_q.delete();
    mon_en = 1'b1;
    do_txn(32'h0000_0020, 1'b0, 1'b0, 0, 0);
    mon_en = 1'b0;
    stall = 1'b0;
    wait_req();
    imem_valid = 1'b1;
    imem_rdata = 32'hFC00_0000;
    @(negedge clk);
    imem_valid = 1'b0;
    chk("halt_exec_iv", 32'(instr_valid), 32'd1);
    @(negedge clk);
    for (int unsigned i = 0; i < 4; i++) begin
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_iv", 32'(instr_valid), 32'd0);
      chk("halt_pc", pc, 32'h4);
      imem_valid = 1'($urandom);
      imem_rdata = $urandom;
      stall = 1'($urandom);
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    chk("halt_rst_pc", pc, 32'h0);
    chk("halt_rst_halted", 32'(halted), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    imem_valid = 1'b0;
    @(negedge clk);
    chk("halt_rst_refetch", 32'(imem_req), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
